// File: rtl/joypad_port_responder.sv
// Controller-port responder: latches pad buttons on OUT0 and shifts one bit
// per completed APU read ($4016 / $4017) onto D[0], standard or Four Score.
module joypad_port_responder #(
  parameter int unsigned FOURSCORE = 0,
  parameter bit          FILL_BIT  = 1'b1
) (
  input  logic       CLK,
  input  logic       n_RES,
  input  logic       OUT0,
  input  logic       n_IN0,
  input  logic       n_IN1,
  input  logic [7:0] pad1,
  input  logic [7:0] pad2,
  input  logic [7:0] pad3,
  input  logic [7:0] pad4,
  output logic [4:0] data_out,
  output logic       data_oe
);

  localparam logic [4:0] LEN = (FOURSCORE != 0) ? 5'd24 : 5'd8;

  logic [1:0][23:0] sr_q, sr_d, ld;
  logic [1:0][4:0]  cnt_q, cnt_d;
  logic [1:0]       nin_q, nin, bitv;

  always_comb begin
    nin = {n_IN1, n_IN0};
    if (FOURSCORE != 0) begin
      ld[0] = {8'h10, pad3, pad1};
      ld[1] = {8'h20, pad4, pad2};
    end else begin
      ld[0] = {16'h0000, pad1};
      ld[1] = {16'h0000, pad2};
    end
    for (int unsigned p = 0; p < 2; p++) begin
      sr_d[p]  = sr_q[p];
      cnt_d[p] = cnt_q[p];
      // Strobe dominates a coincident read release: reload, no shift.
      if (OUT0) begin
        sr_d[p]  = ld[p];
        cnt_d[p] = '0;
      end else if (!nin_q[p] && nin[p]) begin
        sr_d[p] = {1'b0, sr_q[p][23:1]};
        if (cnt_q[p] < LEN) cnt_d[p] = cnt_q[p] + 5'd1;
      end
      bitv[p] = (cnt_q[p] >= LEN) ? FILL_BIT : sr_q[p][0];
    end
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      sr_q  <= '0;
      cnt_q <= '0;
      nin_q <= '1;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      nin_q <= nin;
    end
  end

  always_comb begin
    data_oe  = ~n_IN0 | ~n_IN1;
    data_out = {4'b0000, (~n_IN0 & bitv[0]) | (~n_IN1 & bitv[1])};
  end

endmodule

// File: tb/tb_joypad_port_responder.sv
// Directed bench for joypad_port_responder: one standard and one Four Score
// instance share the port strobes and read enables.
module tb_joypad_port_responder;

  logic       CLK = 1'b0;
  logic       n_RES, OUT0, n_IN0, n_IN1;
  logic [7:0] pad1, pad2, pad3, pad4;
  logic [4:0] dout_std, dout_fs;
  logic       oe_std, oe_fs;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  joypad_port_responder #(.FOURSCORE(0), .FILL_BIT(1'b1)) u_std (
    .CLK(CLK), .n_RES(n_RES), .OUT0(OUT0), .n_IN0(n_IN0), .n_IN1(n_IN1),
    .pad1(pad1), .pad2(pad2), .pad3(pad3), .pad4(pad4),
    .data_out(dout_std), .data_oe(oe_std)
  );

  joypad_port_responder #(.FOURSCORE(1), .FILL_BIT(1'b1)) u_fs (
    .CLK(CLK), .n_RES(n_RES), .OUT0(OUT0), .n_IN0(n_IN0), .n_IN1(n_IN1),
    .pad1(pad1), .pad2(pad2), .pad3(pad3), .pad4(pad4),
    .data_out(dout_fs), .data_oe(oe_fs)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic strobe();
    OUT0 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    OUT0 = 1'b0;
  endtask

  // One complete read: enable low for a cycle, then release (shift on release).
  task automatic rd(input int port, input bit fs, input logic exp, input string tag);
    if (port == 0) n_IN0 = 1'b0; else n_IN1 = 1'b0;
    #1;
    chk(tag, fs ? dout_fs : dout_std, {4'b0000, exp});
    chk({tag, "_oe"}, {4'b0000, fs ? oe_fs : oe_std}, 5'd1);
    @(posedge CLK); @(negedge CLK);
    n_IN0 = 1'b1; n_IN1 = 1'b1;
    #1;
    chk({tag, "_oe_off"}, {4'b0000, fs ? oe_fs : oe_std}, 5'd0);
    @(posedge CLK); @(negedge CLK);
  endtask

  initial begin
    logic [7:0]  p8;
    logic [23:0] p24;

    n_RES = 1'b0; OUT0 = 1'b0; n_IN0 = 1'b1; n_IN1 = 1'b1;
    pad1 = '0; pad2 = '0; pad3 = '0; pad4 = '0;
    #2;
    chk("rst_dout", dout_std, 5'd0);
    chk("rst_oe", {4'b0000, oe_std}, 5'd0);
    n_IN0 = 1'b0;
    #1;
    chk("rst_oe_rd", {4'b0000, oe_std}, 5'd1);
    chk("rst_dout_rd", dout_std, 5'd0);
    n_IN0 = 1'b1;
    @(negedge CLK); n_RES = 1'b1; @(negedge CLK);

    // Standard pad sequence then fill.
    pad1 = 8'b1000_0101; p8 = pad1;
    strobe();
    for (int i = 0; i < 10; i++)
      rd(0, 1'b0, (i < 8) ? p8[i] : 1'b1, $sformatf("std_r%0d", i));

    // Four Score on $4016: pad1, pad3, signature 0x10.
    pad1 = 8'h01; pad3 = 8'h80; p24 = 24'h10_80_01;
    strobe();
    for (int i = 0; i < 26; i++)
      rd(0, 1'b1, (i < 24) ? p24[i] : 1'b1, $sformatf("fs0_r%0d", i));

    // Four Score on $4017: pad2, pad4, signature 0x20.
    pad2 = 8'h00; pad4 = 8'h00; p24 = 24'h20_00_00;
    strobe();
    for (int i = 0; i < 26; i++)
      rd(1, 1'b1, (i < 24) ? p24[i] : 1'b1, $sformatf("fs1_r%0d", i));

    // Both enables low: OR of bits, each port still shifts once.
    pad1 = 8'h01; pad2 = 8'h02;
    strobe();
    n_IN0 = 1'b0; n_IN1 = 1'b0;
    #1;
    chk("both_or", dout_std, 5'd1);
    chk("both_oe", {4'b0000, oe_std}, 5'd1);
    @(posedge CLK); @(negedge CLK);
    n_IN0 = 1'b1; n_IN1 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    rd(0, 1'b0, 1'b0, "both_p0");
    rd(1, 1'b0, 1'b1, "both_p1");

    // OUT0 held high: reads return live A bit, no shifting.
    pad1 = 8'h00; OUT0 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    rd(0, 1'b0, 1'b0, "hold_r0");
    rd(0, 1'b0, 1'b0, "hold_r1");
    n_IN0 = 1'b0;
    #1;
    chk("hold_r2_old", dout_std, 5'd0);
    pad1 = 8'h01;
    #1;
    chk("hold_r2_same_cyc", dout_std, 5'd0);
    @(posedge CLK); @(negedge CLK);
    #1;
    chk("hold_r2_new", dout_std, 5'd1);
    n_IN0 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    rd(0, 1'b0, 1'b1, "hold_r3");
    rd(0, 1'b0, 1'b1, "hold_r4");
    OUT0 = 1'b0;
    @(posedge CLK); @(negedge CLK);
    for (int i = 0; i < 9; i++)
      rd(0, 1'b0, (i == 0 || i >= 8), $sformatf("hold_seq%0d", i));

    // Reset in the middle of a read.
    pad1 = 8'hFF;
    strobe();
    for (int i = 0; i < 3; i++)
      rd(0, 1'b0, 1'b1, $sformatf("mrst_pre%0d", i));
    n_IN0 = 1'b0;
    #1;
    chk("mrst_before", dout_std, 5'd1);
    n_RES = 1'b0;
    #1;
    chk("mrst_dout", dout_std, 5'd0);
    chk("mrst_oe", {4'b0000, oe_std}, 5'd1);
    @(posedge CLK); @(negedge CLK);
    n_RES = 1'b1; n_IN0 = 1'b1;
    #1;
    chk("mrst_after", dout_std, 5'd0);
    @(posedge CLK); @(negedge CLK);
    rd(0, 1'b0, 1'b0, "mrst_nostrobe");
    strobe();
    for (int i = 0; i < 10; i++)
      rd(0, 1'b0, 1'b1, $sformatf("mrst_ff%0d", i));

    // Strobe coinciding with a read release: load wins.
    pad1 = 8'b1000_0101;
    strobe();
    rd(0, 1'b0, 1'b1, "prio_r0");
    n_IN0 = 1'b0;
    @(posedge CLK); @(negedge CLK);
    n_IN0 = 1'b1; OUT0 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    OUT0 = 1'b0;
    rd(0, 1'b0, 1'b1, "prio_a");
    rd(0, 1'b0, 1'b0, "prio_b");
    rd(0, 1'b0, 1'b1, "prio_sel");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
